// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: resolves per-stage stall, timed-stall and flush
// requests into Continue/Stall/Bubble commands per pipeline buffer, with perf counters.
module stall_ctrl #(
  parameter int unsigned N_STAGES = 5,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned PERF_W   = 32,
  localparam int unsigned STG_W   = $clog2(N_STAGES)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [N_STAGES-1:0]   rq_i,
  input  logic [N_STAGES-1:0]   fl_i,
  input  logic                  ld_vld_i,
  input  logic [STG_W-1:0]      ld_stg_i,
  input  logic [CNT_W-1:0]      ld_cnt_i,
  output logic [2*N_STAGES-1:0] stl_o,
  output logic [PERF_W-1:0]     stl_cnt_o,
  output logic [PERF_W-1:0]     fl_cnt_o
);

  localparam logic [1:0] CMD_CONT   = 2'b00;
  localparam logic [1:0] CMD_STALL  = 2'b01;
  localparam logic [1:0] CMD_BUBBLE = 2'b10;

  logic [CNT_W-1:0]    cnt [N_STAGES];
  logic [N_STAGES-1:0] ld_sel;
  logic [N_STAGES-1:0] ld_hit;
  logic [N_STAGES-1:0] eff;
  int unsigned         s_pos;
  int unsigned         f_pos;
  logic                stall_any;
  logic                flush_any;
  logic                take_stall;
  logic                take_flush;

  // Stage 0 cannot redirect itself, so its flush bit carries no meaning.
  logic unused_fl0;
  assign unused_fl0 = fl_i[0];

  always_comb begin
    ld_sel = '0;
    ld_hit = '0;
    eff    = '0;
    for (int unsigned k = 0; k < N_STAGES; k++) begin
      ld_sel[k] = ld_vld_i && (ld_stg_i == STG_W'(k));
      ld_hit[k] = ld_sel[k] && (ld_cnt_i != '0);
      eff[k]    = rq_i[k] || (cnt[k] != '0) || ld_hit[k];
    end
  end

  always_comb begin
    s_pos     = 0;
    f_pos     = 0;
    stall_any = |eff;
    flush_any = 1'b0;
    for (int unsigned k = 0; k < N_STAGES; k++) begin
      if (eff[k]) s_pos = k;
    end
    for (int unsigned k = 1; k < N_STAGES; k++) begin
      if (fl_i[k]) begin
        f_pos     = k;
        flush_any = 1'b1;
      end
    end
    // A stall at or beyond the flushing stage freezes it, so the flush must be reasserted.
    take_stall = stall_any && (!flush_any || (s_pos >= f_pos));
    take_flush = flush_any && !take_stall;
  end

  always_comb begin
    stl_o = '0;
    for (int unsigned k = 0; k < N_STAGES; k++) begin
      if (rst_in) begin
        stl_o[2*k +: 2] = CMD_CONT;
      end else if (!rdy_in) begin
        stl_o[2*k +: 2] = CMD_STALL;
      end else if (take_stall) begin
        if (k <= s_pos)          stl_o[2*k +: 2] = CMD_STALL;
        else if (k == s_pos + 1) stl_o[2*k +: 2] = CMD_BUBBLE;
        else                     stl_o[2*k +: 2] = CMD_CONT;
      end else if (take_flush && (k >= 1) && (k <= f_pos)) begin
        stl_o[2*k +: 2] = CMD_BUBBLE;
      end else begin
        stl_o[2*k +: 2] = CMD_CONT;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned k = 0; k < N_STAGES; k++) cnt[k] <= '0;
      stl_cnt_o <= '0;
      fl_cnt_o  <= '0;
    end else if (rdy_in) begin
      for (int unsigned k = 0; k < N_STAGES; k++) begin
        // An accepted flush wins over a load aimed at a squashed stage.
        if (take_flush && (k <= f_pos))
          cnt[k] <= '0;
        else if (ld_sel[k])
          cnt[k] <= ld_hit[k] ? (ld_cnt_i - CNT_W'(1)) : '0;
        else if (cnt[k] != '0)
          cnt[k] <= cnt[k] - CNT_W'(1);
      end
      if (take_stall && (stl_cnt_o != '1)) stl_cnt_o <= stl_cnt_o + PERF_W'(1);
      if (take_flush && (fl_cnt_o != '1))  fl_cnt_o  <= fl_cnt_o + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: table vectors, multi-cycle corner sequences and random traffic
// checked against a tick-based reference model (stall windows as absolute end ticks).
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, lv;
  logic [4:0]  rq, fl;
  logic [2:0]  ls;
  logic [3:0]  lc;
  logic [9:0]  stl, stl_s;
  logic [31:0] sc, fc;
  logic [3:0]  sc_s, fc_s;

  int checks = 0;
  int errors = 0;

  longint unsigned tick = 0;
  longint unsigned until_t [5];
  longint unsigned m_stl = 0;
  longint unsigned m_fl = 0;
  longint unsigned base;

  typedef struct {
    logic [4:0] rq;
    logic [4:0] fl;
    logic [9:0] exp;
  } vec_t;
  vec_t vt [11];

  stall_ctrl #(.N_STAGES(5), .CNT_W(4), .PERF_W(32)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rq_i(rq), .fl_i(fl),
    .ld_vld_i(lv), .ld_stg_i(ls), .ld_cnt_i(lc),
    .stl_o(stl), .stl_cnt_o(sc), .fl_cnt_o(fc)
  );

  stall_ctrl #(.N_STAGES(5), .CNT_W(4), .PERF_W(4)) dut_sat (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rq_i(rq), .fl_i(fl),
    .ld_vld_i(lv), .ld_stg_i(ls), .ld_cnt_i(lc),
    .stl_o(stl_s), .stl_cnt_o(sc_s), .fl_cnt_o(fc_s)
  );

  always #5 clk = ~clk;

  function automatic void model_eval(output logic [9:0] cmd, output int rule, output int f);
    int s;
    s = -1;
    f = -1;
    for (int k = 0; k < 5; k++)
      if (rq[k] || (tick < until_t[k]) || (lv && (int'(ls) == k) && (lc != 0))) s = k;
    for (int k = 1; k < 5; k++)
      if (fl[k]) f = k;
    cmd  = '0;
    rule = 5;
    if (rst) begin
      rule = 1;
    end else if (!rdy) begin
      rule = 2;
      for (int k = 0; k < 5; k++) cmd[2*k +: 2] = 2'b01;
    end else if (s >= 0 && (f < 0 || s >= f)) begin
      rule = 3;
      for (int k = 0; k <= s; k++) cmd[2*k +: 2] = 2'b01;
      if (s + 1 < 5) cmd[2*(s+1) +: 2] = 2'b10;
    end else if (f >= 0) begin
      rule = 4;
      for (int k = 1; k <= f; k++) cmd[2*k +: 2] = 2'b10;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setin(input logic [4:0] rq_v, input logic [4:0] fl_v, input logic lv_v,
                       input logic [2:0] ls_v, input logic [3:0] lc_v,
                       input logic rdy_v = 1'b1, input logic rst_v = 1'b0);
    rq = rq_v; fl = fl_v; lv = lv_v; ls = ls_v; lc = lc_v; rdy = rdy_v; rst = rst_v;
  endtask

  task automatic cyc(input string name, input bit has_exp = 1'b0, input logic [9:0] exp = '0);
    logic [9:0] mcmd;
    int rule, f;
    @(negedge clk);
    model_eval(mcmd, rule, f);
    check({name, "/cmd"}, 32'(stl), 32'(mcmd));
    check({name, "/cmd_sat"}, 32'(stl_s), 32'(mcmd));
    check({name, "/stl_cnt"}, sc, m_stl[31:0]);
    check({name, "/fl_cnt"}, fc, m_fl[31:0]);
    check({name, "/stl_cnt_sat"}, 32'(sc_s), (m_stl > 15) ? 32'd15 : m_stl[31:0]);
    check({name, "/fl_cnt_sat"}, 32'(fc_s), (m_fl > 15) ? 32'd15 : m_fl[31:0]);
    if (has_exp) check({name, "/expect"}, 32'(stl), 32'(exp));
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 5; k++) until_t[k] = 0;
      m_stl = 0;
      m_fl  = 0;
    end else if (rdy) begin
      if (rule == 3) m_stl++;
      if (rule == 4) begin
        m_fl++;
        for (int k = 0; k <= f; k++) until_t[k] = 0;
      end
      if (lv && (ls < 5) && !(rule == 4 && int'(ls) <= f))
        until_t[ls] = (lc != 0) ? tick + lc : 0;
      tick++;
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < 5; k++) until_t[k] = 0;
    vt[0]  = '{5'b00010, 5'b00000, 10'h025};
    vt[1]  = '{5'b00100, 5'b00000, 10'h095};
    vt[2]  = '{5'b10000, 5'b00000, 10'h155};
    vt[3]  = '{5'b00001, 5'b00000, 10'h009};
    vt[4]  = '{5'b00000, 5'b00100, 10'h028};
    vt[5]  = '{5'b00010, 5'b00100, 10'h028};
    vt[6]  = '{5'b01000, 5'b00100, 10'h255};
    vt[7]  = '{5'b00000, 5'b00001, 10'h000};
    vt[8]  = '{5'b00000, 5'b10000, 10'h2A8};
    vt[9]  = '{5'b00000, 5'b01000, 10'h0A8};
    vt[10] = '{5'b10000, 5'b01000, 10'h155};

    setin(0, 0, 0, 0, 0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    cyc("reset", 1'b1, 10'h000);
    cyc("reset2", 1'b1, 10'h000);
    setin(0, 0, 0, 0, 0);
    cyc("idle", 1'b1, 10'h000);

    for (int i = 0; i < 11; i++) begin
      setin(vt[i].rq, vt[i].fl, 0, 0, 0);
      cyc($sformatf("vec%0d", i), 1'b1, vt[i].exp);
    end

    // timed stall of 3 on stage 3
    base = m_stl;
    setin(0, 0, 1, 3, 3);
    cyc("timed_t0", 1'b1, 10'h255);
    setin(0, 0, 0, 0, 0);
    cyc("timed_t1", 1'b1, 10'h255);
    cyc("timed_t2", 1'b1, 10'h255);
    cyc("timed_t3", 1'b1, 10'h000);
    check("timed_stl_delta", sc, 32'(base + 3));

    // freeze in the middle of a timed stall
    base = m_stl;
    setin(0, 0, 1, 3, 3);
    cyc("frz_t0", 1'b1, 10'h255);
    setin(0, 0, 0, 0, 0, 1'b0);
    cyc("frz_t1", 1'b1, 10'h155);
    cyc("frz_t2", 1'b1, 10'h155);
    setin(0, 0, 0, 0, 0);
    cyc("frz_t3", 1'b1, 10'h255);
    cyc("frz_t4", 1'b1, 10'h255);
    cyc("frz_t5", 1'b1, 10'h000);
    check("frz_stl_delta", sc, 32'(base + 3));

    // flush from EX cancels a stage-1 timer
    setin(0, 0, 1, 1, 8);
    cyc("fcan_t0", 1'b1, 10'h025);
    setin(0, 0, 0, 0, 0);
    cyc("fcan_t1", 1'b1, 10'h025);
    setin(0, 5'b00100, 0, 0, 0);
    cyc("fcan_t2", 1'b1, 10'h028);
    setin(0, 0, 0, 0, 0);
    cyc("fcan_t3", 1'b1, 10'h000);
    cyc("fcan_t4", 1'b1, 10'h000);

    // reset mid-timer
    setin(0, 0, 1, 3, 8);
    cyc("rst_t0", 1'b1, 10'h255);
    setin(0, 0, 0, 0, 0);
    cyc("rst_t1", 1'b1, 10'h255);
    setin(0, 0, 0, 0, 0, 1'b1, 1'b1);
    cyc("rst_t2", 1'b1, 10'h000);
    setin(0, 0, 0, 0, 0);
    cyc("rst_t3", 1'b1, 10'h000);
    cyc("rst_t4", 1'b1, 10'h000);

    // saturation of the 4-bit perf counter
    setin(5'b00010, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc("sat", 1'b1, 10'h025);
    check("sat_stl_cnt4", 32'(sc_s), 32'hF);
    check("sat_stl_cnt32", sc, 32'd20);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      setin(5'($urandom & $urandom & $urandom),
            ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'b0,
            ($urandom_range(0, 3) == 0),
            3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 49) == 0));
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
